// File: rtl/frame_watchdog.sv
// frame_watchdog
// Command-safety gate between the SPI frame buffer and the stepgen/DOUT path.
// Joint commands, enables and digital outputs are latched only from frames
// whose header matches HEADER. If the host goes quiet for TIMEOUT_CYCLES,
// every output is forced to zero and the block waits for REARM_FRAMES
// consecutive good frames before driving the datapath again.
module frame_watchdog #(
   parameter int          NUM_JOINTS     = 5,
   parameter int          TIMEOUT_CYCLES = 2400000,
   parameter int          REARM_FRAMES   = 2,
   parameter logic [31:0] HEADER         = 32'h74697277
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      frame_valid,
   input  logic [31:0]               header_rx,
   input  logic [32*NUM_JOINTS-1:0]  freq_cmd_in,
   input  logic [NUM_JOINTS-1:0]     enable_in,
   input  logic [7:0]                dout_in,
   output logic [32*NUM_JOINTS-1:0]  freq_cmd_out,
   output logic [NUM_JOINTS-1:0]     enable_out,
   output logic [7:0]                dout_out,
   output logic [1:0]                state,
   output logic [15:0]               timeout_count
);

   // Watchdog width covers 0..TIMEOUT_CYCLES-1.
   localparam int               WD_W         = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0]  WD_LIMIT     = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_ONE       = WD_W'(1);
   localparam logic [3:0]       REARM_TARGET = 4'(REARM_FRAMES);

   typedef enum logic [1:0] {
      ST_INIT    = 2'd0,
      ST_RUN     = 2'd1,
      ST_TIMEOUT = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [WD_W-1:0]   wd_reg, wd_next;
   logic [3:0]        rearm_reg, rearm_next;
   logic [15:0]       tc_reg, tc_next;

   logic                      good_frame;
   logic                      wd_at_limit;
   logic [3:0]                rearm_inc;
   logic                      do_latch;
   logic                      do_clear;
   logic [32*NUM_JOINTS-1:0]  freq_gated;

   logic [32*NUM_JOINTS-1:0]  freq_out_reg;
   logic [NUM_JOINTS-1:0]     enable_out_reg;
   logic [7:0]                dout_out_reg;

   // A frame counts only when the header matches; bad headers are invisible.
   assign good_frame  = frame_valid && (header_rx == HEADER);
   assign wd_at_limit = (wd_reg == WD_LIMIT);
   assign rearm_inc   = rearm_reg + 4'd1;

   // Disabled joints are commanded to zero frequency regardless of the host value.
   generate
      for (genvar gi = 0; gi < NUM_JOINTS; gi++) begin : g_lane
         assign freq_gated[32*gi +: 32] = enable_in[gi] ? freq_cmd_in[32*gi +: 32] : 32'd0;
      end
   endgenerate

   // Next-state, watchdog, re-arm and event-counter logic.
   always_comb begin
      state_next = state_reg;
      wd_next    = wd_reg;
      rearm_next = rearm_reg;
      tc_next    = tc_reg;
      do_latch   = 1'b0;
      do_clear   = 1'b0;

      case (state_reg)
         ST_INIT: begin
            wd_next = '0;
            if (good_frame) begin
               state_next = ST_RUN;
               do_latch   = 1'b1;
            end
         end

         ST_RUN: begin
            if (good_frame) begin
               // A good frame on the limit cycle still restarts the watchdog.
               wd_next  = '0;
               do_latch = 1'b1;
            end else if (wd_at_limit) begin
               state_next = ST_TIMEOUT;
               wd_next    = '0;
               rearm_next = 4'd0;
               do_clear   = 1'b1;
               if (tc_reg != 16'hFFFF) begin
                  tc_next = tc_reg + 16'd1;
               end
            end else begin
               wd_next = wd_reg + WD_ONE;
            end
         end

         ST_TIMEOUT: begin
            if (good_frame) begin
               wd_next = '0;
               if (rearm_inc == REARM_TARGET) begin
                  state_next = ST_RUN;
                  rearm_next = 4'd0;
                  do_latch   = 1'b1;
               end else begin
                  rearm_next = rearm_inc;
               end
            end else if (wd_at_limit) begin
               // Re-arm frames must be consecutive within one watchdog window.
               rearm_next = 4'd0;
               wd_next    = '0;
            end else begin
               wd_next = wd_reg + WD_ONE;
            end
         end

         default: begin
            state_next = ST_INIT;
            wd_next    = '0;
            rearm_next = 4'd0;
            do_clear   = 1'b1;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_INIT;
         wd_reg    <= '0;
         rearm_reg <= 4'd0;
         tc_reg    <= 16'd0;
      end else begin
         state_reg <= state_next;
         wd_reg    <= wd_next;
         rearm_reg <= rearm_next;
         tc_reg    <= tc_next;
      end
   end

   // Output registers: load on an accepted frame, zero on timeout, else hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         freq_out_reg   <= '0;
         enable_out_reg <= '0;
         dout_out_reg   <= 8'd0;
      end else if (do_latch) begin
         freq_out_reg   <= freq_gated;
         enable_out_reg <= enable_in;
         dout_out_reg   <= dout_in;
      end else if (do_clear) begin
         freq_out_reg   <= '0;
         enable_out_reg <= '0;
         dout_out_reg   <= 8'd0;
      end
   end

   assign freq_cmd_out  = freq_out_reg;
   assign enable_out    = enable_out_reg;
   assign dout_out      = dout_out_reg;
   assign state         = state_reg;
   assign timeout_count = tc_reg;

endmodule

// File: tb/tb_frame_watchdog.sv
// Testbench for frame_watchdog: scoreboard of expected values queued when a
// stimulus step is driven and compared once the DUT has produced its output.
`timescale 1ns/1ps
module tb_frame_watchdog;

   localparam logic [31:0] HDR = 32'h74697277;

   logic clk;
   logic rst;

   // Main instance: TIMEOUT_CYCLES=100, REARM_FRAMES=2
   logic          frame_valid;
   logic [31:0]   header_rx;
   logic [159:0]  freq_cmd_in;
   logic [4:0]    enable_in;
   logic [7:0]    dout_in;
   logic [159:0]  freq_cmd_out;
   logic [4:0]    enable_out;
   logic [7:0]    dout_out;
   logic [1:0]    state;
   logic [15:0]   timeout_count;

   // Saturation instance: TIMEOUT_CYCLES=4, REARM_FRAMES=1
   logic          fv_s;
   logic [159:0]  freq_out_s;
   logic [4:0]    en_out_s;
   logic [7:0]    dout_out_s;
   logic [1:0]    state_s;
   logic [15:0]   tc_s;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_t;
   sb_t sb_q[$];

   frame_watchdog #(.NUM_JOINTS(5), .TIMEOUT_CYCLES(100), .REARM_FRAMES(2), .HEADER(HDR)) dut (
      .clk(clk), .rst(rst), .frame_valid(frame_valid), .header_rx(header_rx),
      .freq_cmd_in(freq_cmd_in), .enable_in(enable_in), .dout_in(dout_in),
      .freq_cmd_out(freq_cmd_out), .enable_out(enable_out), .dout_out(dout_out),
      .state(state), .timeout_count(timeout_count)
   );

   frame_watchdog #(.NUM_JOINTS(5), .TIMEOUT_CYCLES(4), .REARM_FRAMES(1), .HEADER(HDR)) dut_s (
      .clk(clk), .rst(rst), .frame_valid(fv_s), .header_rx(HDR),
      .freq_cmd_in(160'd0), .enable_in(5'd0), .dout_in(8'd0),
      .freq_cmd_out(freq_out_s), .enable_out(en_out_s), .dout_out(dout_out_s),
      .state(state_s), .timeout_count(tc_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         0:       obs = {30'd0, state};
         1:       obs = freq_cmd_out[31:0];
         2:       obs = freq_cmd_out[63:32];
         3:       obs = {27'd0, enable_out};
         4:       obs = {24'd0, dout_out};
         5:       obs = {16'd0, timeout_count};
         6:       obs = {31'd0, |freq_cmd_out[159:64]};
         10:      obs = {30'd0, state_s};
         11:      obs = {16'd0, tc_s};
         default: obs = {8'd0, |freq_out_s, en_out_s, dout_out_s, 10'd0};
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] exp);
      sb_q.push_back('{tag, sel, exp});
   endtask

   task automatic push_all(input string pfx, input logic [1:0] st, input logic [31:0] f0,
                           input logic [31:0] f1, input logic [4:0] en, input logic [7:0] d,
                           input logic [15:0] tc);
      push({pfx, ".state"}, 0, {30'd0, st});
      push({pfx, ".freq0"}, 1, f0);
      push({pfx, ".freq1"}, 2, f1);
      push({pfx, ".en"},    3, {27'd0, en});
      push({pfx, ".dout"},  4, {24'd0, d});
      push({pfx, ".tc"},    5, {16'd0, tc});
      push({pfx, ".lanes2to4"}, 6, 32'd0);
   endtask

   task automatic drain();
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, obs(e.sel), e.exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One frame on the main instance; outputs are valid on return.
   task automatic send(input logic [31:0] hdr, input logic [31:0] f0, input logic [31:0] f1,
                       input logic [4:0] en, input logic [7:0] d);
      frame_valid = 1'b1;
      header_rx   = hdr;
      freq_cmd_in = {32'h0000_0777, 32'h0000_0666, 32'h0000_0555, f1, f0};
      enable_in   = en;
      dout_in     = d;
      cyc(1);
      frame_valid = 1'b0;
      $display("frame hdr=%h f0=%h f1=%h en=%b dout=%h -> state=%0d tc=%0d",
               hdr, f0, f1, en, d, state, timeout_count);
   endtask

   initial begin
      rst = 1'b1;
      frame_valid = 1'b0; header_rx = 32'd0; freq_cmd_in = '0; enable_in = '0; dout_in = '0;
      fv_s = 1'b0;

      // Reset values
      push_all("reset", 2'd0, 32'd0, 32'd0, 5'd0, 8'd0, 16'd0);
      cyc(3);
      drain();
      rst = 1'b0;

      // Idle in INIT: never times out
      push_all("idle_init", 2'd0, 32'd0, 32'd0, 5'd0, 8'd0, 16'd0);
      cyc(1000);
      drain();

      // First good frame: enter RUN and latch, lane 1 gated off
      push_all("first_gf", 2'd1, 32'h0000_1000, 32'd0, 5'b00001, 8'hA5, 16'd0);
      send(HDR, 32'h0000_1000, 32'hFFFF_FFFB, 5'b00001, 8'hA5);
      drain();

      // 99 idle edges: still RUN, outputs held
      push_all("run_hold", 2'd1, 32'h0000_1000, 32'd0, 5'b00001, 8'hA5, 16'd0);
      cyc(99);
      drain();

      // 100th idle edge: timeout
      push_all("timeout1", 2'd2, 32'd0, 32'd0, 5'd0, 8'd0, 16'd1);
      cyc(1);
      drain();

      // Bad header in TIMEOUT: nothing changes
      push_all("bad_hdr", 2'd2, 32'd0, 32'd0, 5'd0, 8'd0, 16'd1);
      send(32'hDEAD_BEEF, 32'h1111, 32'h2222, 5'b11111, 8'hFF);
      drain();

      // First re-arm frame: still TIMEOUT, nothing latched
      push_all("rearm1", 2'd2, 32'd0, 32'd0, 5'd0, 8'd0, 16'd1);
      send(HDR, 32'h1111, 32'h2222, 5'b00011, 8'h11);
      drain();

      // Second re-arm frame 50 cycles later: RUN with this frame's data
      cyc(49);
      push_all("rearm2", 2'd1, 32'h0000_2222, 32'h0000_3333, 5'b00011, 8'h3C, 16'd1);
      send(HDR, 32'h0000_2222, 32'h0000_3333, 5'b00011, 8'h3C);
      drain();

      // Timeout again, then re-arm frames 120 cycles apart
      cyc(100);
      push_all("timeout2", 2'd2, 32'd0, 32'd0, 5'd0, 8'd0, 16'd2);
      drain();
      send(HDR, 32'h5, 32'h6, 5'b00011, 8'h01);
      cyc(119);
      push_all("rearm_gap", 2'd2, 32'd0, 32'd0, 5'd0, 8'd0, 16'd2);
      send(HDR, 32'h7, 32'h8, 5'b00011, 8'h02);
      drain();
      push_all("rearm_back", 2'd1, 32'h9, 32'hA, 5'b00011, 8'h03, 16'd2);
      send(HDR, 32'h9, 32'hA, 5'b00011, 8'h03);
      drain();

      // Good frame exactly on the limit edge: no timeout
      cyc(99);
      push_all("gf_at_limit", 2'd1, 32'h0000_0042, 32'd0, 5'b00001, 8'h5A, 16'd2);
      send(HDR, 32'h0000_0042, 32'h0000_0043, 5'b00001, 8'h5A);
      drain();

      // Bad header on the limit edge: timeout still fires
      cyc(99);
      push_all("bad_at_limit", 2'd2, 32'd0, 32'd0, 5'd0, 8'd0, 16'd3);
      send(32'h0BAD_0BAD, 32'h1, 32'h2, 5'b00011, 8'h77);
      drain();

      // Reset mid re-arm, asserted between edges
      send(HDR, 32'h1, 32'h2, 5'b00011, 8'h77);
      #3 rst = 1'b1;
      #1;
      push_all("rst_rearm", 2'd0, 32'd0, 32'd0, 5'd0, 8'd0, 16'd0);
      drain();
      #2 rst = 1'b0;
      cyc(1);

      // From INIT a single frame enters RUN
      push_all("after_rst", 2'd1, 32'h0000_00AB, 32'h0000_00CD, 5'b00011, 8'hC3, 16'd0);
      send(HDR, 32'h0000_00AB, 32'h0000_00CD, 5'b00011, 8'hC3);
      drain();

      // Reset mid RUN: outputs drop without a clock edge
      #3 rst = 1'b1;
      #1;
      push_all("rst_run", 2'd0, 32'd0, 32'd0, 5'd0, 8'd0, 16'd0);
      drain();
      #2 rst = 1'b0;
      cyc(1);

      // Saturation of timeout_count on the fast instance
      $display("saturation run: 65537 timeouts");
      for (int i = 0; i < 65537; i++) begin
         fv_s = 1'b1;
         cyc(1);
         fv_s = 1'b0;
         cyc(4);
         if (i == 0) begin
            push("sat.first", 11, 32'd1);
            push("sat.state", 10, 32'd2);
            drain();
         end
         if (i == 65533) begin
            push("sat.fffe", 11, 32'h0000_FFFE);
            drain();
         end
      end
      push("sat.ffff", 11, 32'h0000_FFFF);
      push("sat.state_end", 10, 32'd2);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_watchdog.md
# frame_watchdog

Command-safety controller between the SPI slave's received-frame buffer and the stepgen/DOUT datapath. It latches joint frequency commands, joint enables and digital outputs only from frames with a valid header. It forces every joint to zero frequency and every output low when the host stops sending frames. After a timeout, it re-arms only after several consecutive good frames.

## Interface
- NUM_JOINTS, 5, number of joint command lanes (1..8)
- TIMEOUT_CYCLES, 2400000, clk cycles without a valid frame before timeout (50 ms at 48 MHz); minimum 4
- REARM_FRAMES, 2, consecutive valid frames required to leave TIMEOUT (1..15)
- HEADER, 32'h74697277, required header_rx value

- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- frame_valid  in  1  one-cycle pulse: new frame present on header_rx/freq_cmd_in/enable_in/dout_in
- header_rx  in  32  frame header
- freq_cmd_in  in  32*NUM_JOINTS  signed joint commands; joint j at [32j+31:32j]
- enable_in  in  NUM_JOINTS  per-joint enable bits
- dout_in  in  8  digital output bits
- freq_cmd_out  out  32*NUM_JOINTS  gated commands to stepgens
- enable_out  out  NUM_JOINTS  gated enables
- dout_out  out  8  gated digital outputs
- state  out  2  0=INIT, 1=RUN, 2=TIMEOUT
- timeout_count  out  16  number of RUN->TIMEOUT events, saturating

## Operation
- Good frame (gf): frame_valid=1 and header_rx==HEADER. A frame_valid with a wrong header is ignored entirely: no latch, no watchdog restart, no re-arm credit.
- Latch on gf while in RUN, or on the gf that completes entry to RUN:
  - freq_cmd_out[j] <= enable_in[j] ? freq_cmd_in[j] : 0
  - enable_out <= enable_in
  - dout_out <= dout_in
- Outputs hold between latches. Outputs are all zero in INIT and TIMEOUT.
- Watchdog counter wd (width ceil(log2(TIMEOUT_CYCLES))):
  - gf: wd <= 0.
  - No gf, INIT state: wd holds at 0.
  - No gf, RUN or TIMEOUT state: wd <= wd+1.
- INIT: on the first gf, go to RUN and latch that frame.
- RUN: if no gf and wd==TIMEOUT_CYCLES-1, go to TIMEOUT on that edge:
  - zero all outputs
  - wd<=0, rearm<=0
  - timeout_count<=timeout_count+1, saturating at 16'hFFFF
- TIMEOUT, re-arm counter rearm (4 bits):
  - gf: rearm<=rearm+1.
  - If rearm+1==REARM_FRAMES, go to RUN, latch the frame, clear rearm.
  - If no gf and wd==TIMEOUT_CYCLES-1: rearm<=0, wd<=0, stay in TIMEOUT, no timeout_count increment.
- Simultaneous events:
  - gf on the same cycle wd reaches its limit: gf wins (restart, no timeout).
  - frame_valid with a bad header at the limit cycle: the timeout still fires.
- Reset (asynchronous, any time including mid-frame or mid-re-arm):
  - state=INIT, wd=0, rearm=0, timeout_count=0
  - freq_cmd_out=0, enable_out=0, dout_out=0
- rst deassertion needs no synchronizer here; the top level owns reset synchronization.

## Timing
- Latency: a gf sampled at edge N appears on the outputs after edge N (registered, 1 cycle).
- In RUN, a timeout fires at the TIMEOUT_CYCLES-th consecutive edge without a gf after the last gf. Outputs are zero from that edge.
- state and timeout_count are registered and update on the same edge as the transition.
- All outputs come directly from flops; no combinational paths from inputs to outputs.
- frame_valid longer than 1 cycle counts as one gf per high cycle. Upstream guarantees single-cycle pulses.

## Test plan
- Reset then idle 1000 cycles (TIMEOUT_CYCLES=100): state stays 0, all outputs 0, timeout_count stays 0.
- gf with freq_cmd_in[0]=32'h00001000, [1]=-5, enable_in=5'b00001, dout_in=8'hA5: one cycle later freq_cmd_out[0]=32'h1000, freq_cmd_out[1]=0, dout_out=8'hA5, state=1.
- RUN, no frames for 100 cycles: on the 100th edge state=2, outputs 0, timeout_count=1. Repeat with a gf exactly on cycle 100: state stays 1.
- TIMEOUT, REARM_FRAMES=2:
  - Bad-header frame: no change.
  - One gf: still state 2.
  - Second gf 50 cycles later: state=1 and the second frame's data is latched.
  - Repeat with 120 cycles between the two gfs: rearm clears and state stays 2.
- Assert rst mid-re-arm (rearm=1) and mid-RUN: outputs zero immediately (asynchronously), state=0, timeout_count=0.
- Force 65537 timeouts (TIMEOUT_CYCLES=4, REARM_FRAMES=1, one gf after each): timeout_count saturates at 16'hFFFF.
